// File: rtl/latch_write_arbiter_pkg.sv
// Shared FSM encoding and sizing helpers for the latch write arbiter.
// The optional LATCH_READBACK_EN build adds a latch Q readback check.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // One down-counter serves every phase, so it is sized for the longest one.
  function automatic int cnt_width(input int setup_cyc, input int pulse_w, input int hold_cyc);
    int longest;
    longest = setup_cyc;
    if (pulse_w > longest) longest = pulse_w;
    if (hold_cyc > longest) longest = hold_cyc;
    return $clog2(longest) + 1;
  endfunction

  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/latch_write_arbiter_if.sv
// Client/latch-side bundle for latch_write_arbiter; slave is the arbiter side.
// With LATCH_READBACK_EN defined it also carries q_i (latch Q) and err_o.
interface latch_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        done_o;
  logic                      busy_o;
  logic [DATA_W-1:0]         latch_d_o;
  logic                      latch_c_o;
`ifdef LATCH_READBACK_EN
  logic [DATA_W-1:0]         q_i;
  logic                      err_o;

  modport master (
    output req_i, data_i, q_i,
    input  gnt_o, done_o, busy_o, latch_d_o, latch_c_o, err_o
  );

  modport slave (
    input  req_i, data_i, q_i,
    output gnt_o, done_o, busy_o, latch_d_o, latch_c_o, err_o
  );
`else
  modport master (
    output req_i, data_i,
    input  gnt_o, done_o, busy_o, latch_d_o, latch_c_o
  );

  modport slave (
    input  req_i, data_i,
    output gnt_o, done_o, busy_o, latch_d_o, latch_c_o
  );
`endif

endinterface

// File: rtl/latch_write_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, searching upward
// cyclically; ptr moves just past the winner whenever accept is strobed.
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] winner
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Shares one D-latch bank between requesters: each write runs
// SETUP -> ENABLE (C high) -> HOLD so D is stable while C is high.
// Optional LATCH_READBACK_EN compares latch Q against the written data.
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_W   = 2,
  parameter int HOLD_CYC  = 1
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  latch_write_arbiter_if.slave  bus
);

  localparam int CNT_W = cnt_width(SETUP_CYC, PULSE_W, HOLD_CYC);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_REQ-1:0]  winner;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_nxt;
  logic [NUM_REQ-1:0]  done_reg, done_nxt;
  logic [DATA_W-1:0]   d_reg, d_nxt, win_data;
  logic                busy_reg, busy_nxt;
  logic                c_reg, c_nxt;
  logic                accept;
  logic                last_hold_nxt;
`ifdef LATCH_READBACK_EN
  logic                err_reg, err_nxt;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req     (bus.req_i),
    .accept  (accept),
    .winner  (winner)
  );

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner[k]) win_data = win_data | bus.data_i[k*DATA_W +: DATA_W];
    end
  end

  // Outputs are computed for the state being entered and registered on the edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt_reg;
    d_nxt     = d_reg;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req_i) begin
          state_nxt = SETUP;
          cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          gnt_nxt   = winner;
          d_nxt     = win_data;
          accept    = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = ENABLE;
          cnt_nxt   = CNT_W'(PULSE_W - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ENABLE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    last_hold_nxt = (state_nxt == HOLD) && (cnt_nxt == '0);
    busy_nxt      = (state_nxt != IDLE);
    c_nxt         = (state_nxt == ENABLE);
    done_nxt      = last_hold_nxt ? gnt_nxt : '0;
`ifdef LATCH_READBACK_EN
    err_nxt       = last_hold_nxt && (bus.q_i != d_nxt);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt_reg  <= '0;
      done_reg <= '0;
      d_reg    <= '0;
      busy_reg <= 1'b0;
      c_reg    <= 1'b0;
`ifdef LATCH_READBACK_EN
      err_reg  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gnt_reg  <= gnt_nxt;
      done_reg <= done_nxt;
      d_reg    <= d_nxt;
      busy_reg <= busy_nxt;
      c_reg    <= c_nxt;
`ifdef LATCH_READBACK_EN
      err_reg  <= err_nxt;
`endif
    end
  end

  assign bus.gnt_o     = gnt_reg;
  assign bus.done_o    = done_reg;
  assign bus.busy_o    = busy_reg;
  assign bus.latch_d_o = d_reg;
  assign bus.latch_c_o = c_reg;
`ifdef LATCH_READBACK_EN
  assign bus.err_o     = err_reg;
`endif

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Scoreboard bench for latch_write_arbiter: directed writes push expected
// completions; a negedge monitor checks them when done_o pulses.
module tb_latch_write_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] data;
    logic       err;
  } txn_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  txn_t exp_q[$];

  latch_write_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  latch_write_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .SETUP_CYC (1),
    .PULSE_W   (2),
    .HOLD_CYC  (1)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LATCH_READBACK_EN
  // Behavioural D-latch standing in for the real bank, with a stuck-at-0 override.
  logic [7:0] q_latch;
  logic       q_force;
  initial begin
    q_latch = 8'h00;
    q_force = 1'b0;
  end
  always @(bus.latch_c_o or bus.latch_d_o) begin
    if (bus.latch_c_o) q_latch = bus.latch_d_o;
  end
  assign bus.q_i = q_force ? 8'h00 : q_latch;
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [31:0] data);
    bus.req_i  = req;
    bus.data_i = data;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus(4'b0000, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (bus.busy_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'b0, bus.busy_o}, 32'd0);
  endtask

  task automatic waitEnable(input string name);
    int n;
    n = 0;
    while (!bus.latch_c_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'b0, bus.latch_c_o}, 32'd1);
  endtask

  task automatic doWrite(input logic [3:0] req, input logic [31:0] data,
                         input logic [3:0] exp_gnt, input logic [7:0] exp_data, input logic exp_err);
    txn_t t;
    t.gnt  = exp_gnt;
    t.data = exp_data;
    t.err  = exp_err;
    exp_q.push_back(t);
    applyStimulus(req, data);
    @(negedge clk);
    applyStimulus(4'b0000, data);
    waitIdle("write_idle");
  endtask

  // Completion monitor: every done_o pulse must match the oldest expected write.
  always @(negedge clk) begin : monitor
    txn_t t;
    if (bus.done_o != 4'b0000) begin
      if (exp_q.size() == 0) begin
        checkOutput("done_unexpected", {28'b0, bus.done_o}, 32'd0);
      end else begin
        t = exp_q.pop_front();
        checkOutput("done_grant", {28'b0, bus.done_o}, {28'b0, t.gnt});
        checkOutput("done_gnt_o", {28'b0, bus.gnt_o}, {28'b0, t.gnt});
        checkOutput("done_data", {24'b0, bus.latch_d_o}, {24'b0, t.data});
`ifdef LATCH_READBACK_EN
        checkOutput("done_err", {31'b0, bus.err_o}, {31'b0, t.err});
`endif
      end
    end else begin
`ifdef LATCH_READBACK_EN
      if (rst_n) checkOutput("err_outside_done", {31'b0, bus.err_o}, 32'd0);
`endif
    end
    if (bus.latch_c_o && exp_q.size() > 0) begin
      checkOutput("pulse_data", {24'b0, bus.latch_d_o}, {24'b0, exp_q[0].data});
    end
  end

  initial begin : stimulus
    txn_t       t;
    logic [3:0] rr_order [5];
    logic [3:0] prev_gnt;
    int         starts;
    int         last_start;
    int         n;

    errors = 0;
    checks = 0;
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with every request asserted: nothing may be granted.
    rst_n = 1'b0;
    applyStimulus(4'b1111, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    checkOutput("reset_gnt", {28'b0, bus.gnt_o}, 32'd0);
    checkOutput("reset_busy", {31'b0, bus.busy_o}, 32'd0);
    checkOutput("reset_c", {31'b0, bus.latch_c_o}, 32'd0);
    checkOutput("reset_d", {24'b0, bus.latch_d_o}, 32'h00);
    checkOutput("reset_done", {28'b0, bus.done_o}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 32'h0);

    // Single write from requester 2, cycle-by-cycle.
    @(negedge clk);
    t = '{gnt: 4'b0100, data: 8'hA5, err: 1'b0};
    exp_q.push_back(t);
    applyStimulus(4'b0100, 32'h00A50000);
    @(negedge clk);
    applyStimulus(4'b0000, 32'h00A50000);
    checkOutput("t2_c1_gnt", {28'b0, bus.gnt_o}, 32'b0100);
    checkOutput("t2_c1_d", {24'b0, bus.latch_d_o}, 32'hA5);
    checkOutput("t2_c1_c", {31'b0, bus.latch_c_o}, 32'd0);
    checkOutput("t2_c1_busy", {31'b0, bus.busy_o}, 32'd1);
    @(negedge clk);
    checkOutput("t2_c2_c", {31'b0, bus.latch_c_o}, 32'd1);
    checkOutput("t2_c2_gnt", {28'b0, bus.gnt_o}, 32'b0100);
    @(negedge clk);
    checkOutput("t2_c3_c", {31'b0, bus.latch_c_o}, 32'd1);
    @(negedge clk);
    checkOutput("t2_c4_c", {31'b0, bus.latch_c_o}, 32'd0);
    checkOutput("t2_c4_done", {28'b0, bus.done_o}, 32'b0100);
    checkOutput("t2_c4_gnt", {28'b0, bus.gnt_o}, 32'b0100);
    @(negedge clk);
    checkOutput("t2_c5_busy", {31'b0, bus.busy_o}, 32'd0);
    checkOutput("t2_c5_gnt", {28'b0, bus.gnt_o}, 32'd0);
    checkOutput("t2_c5_done", {28'b0, bus.done_o}, 32'd0);
    checkOutput("t2_c5_d_kept", {24'b0, bus.latch_d_o}, 32'hA5);

    // Round-robin fairness with all requests held from a fresh pointer.
    applyReset();
    for (int i = 0; i < 5; i++) begin
      t.gnt  = rr_order[i];
      t.data = (i == 0 || i == 4) ? 8'h11 : (i == 1) ? 8'h22 : (i == 2) ? 8'h33 : 8'h44;
      t.err  = 1'b0;
      exp_q.push_back(t);
    end
    applyStimulus(4'b1111, 32'h44332211);
    starts     = 0;
    last_start = 0;
    prev_gnt   = 4'b0000;
    for (int cyc = 0; cyc < 60 && starts < 5; cyc++) begin
      @(negedge clk);
      if (bus.gnt_o != 4'b0000 && prev_gnt == 4'b0000) begin
        checkOutput("t3_order", {28'b0, bus.gnt_o}, {28'b0, rr_order[starts]});
        if (starts > 0) checkOutput("t3_spacing", cyc - last_start, 32'd5);
        last_start = cyc;
        starts++;
        if (starts == 5) applyStimulus(4'b0000, 32'h44332211);
      end
      prev_gnt = bus.gnt_o;
    end
    checkOutput("t3_grant_count", starts, 32'd5);
    waitIdle("t3_idle");

    // Request drop and data change after grant must not disturb the write.
    @(negedge clk);
    t = '{gnt: 4'b0001, data: 8'h3C, err: 1'b0};
    exp_q.push_back(t);
    applyStimulus(4'b0001, 32'h0000003C);
    waitEnable("t4_enable");
    applyStimulus(4'b0000, 32'h000000FF);
    @(negedge clk);
    checkOutput("t4_d_during_pulse", {24'b0, bus.latch_d_o}, 32'h3C);
    waitIdle("t4_idle");
    checkOutput("t4_d_after", {24'b0, bus.latch_d_o}, 32'h3C);

    // Reset in the middle of the enable pulse, then a fresh arbitration.
    @(negedge clk);
    applyStimulus(4'b0001, 32'h00000077);
    waitEnable("t5_enable");
    rst_n = 1'b0;
    applyStimulus(4'b0000, 32'h0);
    @(negedge clk);
    checkOutput("t5_rst_c", {31'b0, bus.latch_c_o}, 32'd0);
    checkOutput("t5_rst_gnt", {28'b0, bus.gnt_o}, 32'd0);
    checkOutput("t5_rst_busy", {31'b0, bus.busy_o}, 32'd0);
    checkOutput("t5_rst_d", {24'b0, bus.latch_d_o}, 32'd0);
    rst_n = 1'b1;
    t = '{gnt: 4'b0010, data: 8'h5B, err: 1'b0};
    exp_q.push_back(t);
    applyStimulus(4'b1010, 32'h9D005B00);
    @(negedge clk);
    checkOutput("t5_regrant", {28'b0, bus.gnt_o}, 32'b0010);
    applyStimulus(4'b0000, 32'h9D005B00);
    waitIdle("t5_idle");

`ifdef LATCH_READBACK_EN
    // Readback: a following latch gives no error, a stuck latch flags the done cycle.
    @(negedge clk);
    doWrite(4'b0001, 32'h0000005A, 4'b0001, 8'h5A, 1'b0);
    @(negedge clk);
    q_force = 1'b1;
    doWrite(4'b0001, 32'h0000005A, 4'b0001, 8'h5A, 1'b1);
    q_force = 1'b0;
`else
    // Back-to-back writes from one requester re-arbitrate normally.
    @(negedge clk);
    doWrite(4'b1000, 32'h5A000000, 4'b1000, 8'h5A, 1'b0);
    @(negedge clk);
    doWrite(4'b1000, 32'hC3000000, 4'b1000, 8'hC3, 1'b0);
`endif

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
